// File: rtl/aes_ctr_rej_sampler.sv
// -----------------------------------------------------------------------------
// aes_ctr_rej_sampler
//
// Purpose:
//   Consumes 512-bit AES-256-CTR keystream batches and parses them into 12-bit
//   candidates by rejection sampling mod Q. It emits one uniform polynomial
//   coefficient per cycle to the NTT/matrix storage stage.
//   Up to two leftover bytes are carried into the next batch, so no keystream
//   byte is lost at a batch boundary.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        1-cycle pulse that begins a new polynomial (used only in IDLE)
//   batch_in     keystream batch; byte k = batch_in[8k+7:8k]
//   batch_valid  batch_in valid
//   batch_ready  sampler accepts a batch this cycle (high only in FILL)
//   coef_out     accepted coefficient
//   coef_valid   coef_out valid
//   coef_ready   downstream accepts coef_out
//   coef_idx     index 0..N_COEF-1 of coef_out
//   poly_done    1-cycle pulse after coefficient N_COEF-1 has handshaken
//   busy         high in every state except IDLE
//   rej_cnt      (REJ_STATS_EN only) rejected candidates in the current polynomial
//
// Configuration:
//   REJ_STATS_EN  When defined, adds the rej_cnt output and its saturating counter.
// -----------------------------------------------------------------------------
module aes_ctr_rej_sampler #(
    parameter int BATCH_BYTES = 64,
    parameter int COEF_W      = 12,
    parameter int Q           = 3329,
    parameter int N_COEF      = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [BATCH_BYTES*8-1:0] batch_in,
    input  logic                     batch_valid,
    output logic                     batch_ready,
    output logic [COEF_W-1:0]        coef_out,
    output logic                     coef_valid,
    input  logic                     coef_ready,
    output logic [7:0]               coef_idx,
    output logic                     poly_done,
    output logic                     busy
`ifdef REJ_STATS_EN
    ,
    output logic [15:0]              rej_cnt
`endif
);

    localparam int BUF_BYTES = BATCH_BYTES + 2;
    localparam int BUF_W     = BUF_BYTES * 8;
    localparam logic [COEF_W-1:0] Q_C    = COEF_W'(Q);
    localparam logic [8:0]        LAST_C = 9'(N_COEF - 1);
    localparam logic [6:0]        BATCH_C = 7'(BATCH_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_PARSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [6:0]       occ_q, occ_d;
    logic             phase_q, phase_d;
    logic [8:0]       count_q, count_d;

    logic [7:0]        b0_s, b1_s, b2_s;
    logic [COEF_W-1:0] cand_s;
    logic              have_cand_s;
    logic              cand_ok_s;
    logic              advance_s;
    logic [BUF_W-1:0]  app_s;

`ifdef REJ_STATS_EN
    logic [15:0] rej_q, rej_d;
`endif

    // Head triple of the byte buffer and the candidate selected by phase.
    assign b0_s   = buf_q[7:0];
    assign b1_s   = buf_q[15:8];
    assign b2_s   = buf_q[23:16];
    assign cand_s = phase_q ? {b2_s, b1_s[7:4]} : {b1_s[3:0], b0_s};

    // A candidate exists in PARSE unless the buffer ran dry on a triple boundary.
    assign have_cand_s = (state_q == S_PARSE) && !((occ_q < 7'd3) && (phase_q == 1'b0));
    assign cand_ok_s   = have_cand_s && (cand_s < Q_C);
    // Rejected candidates never wait for downstream; accepted ones wait for coef_ready.
    assign advance_s   = have_cand_s && (!cand_ok_s || coef_ready);

    // Outputs are decoded only from registered state, never from inputs.
    assign coef_valid  = cand_ok_s;
    assign coef_out    = cand_ok_s ? cand_s : '0;
    assign coef_idx    = count_q[7:0];
    assign batch_ready = (state_q == S_FILL);
    assign poly_done   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
`ifdef REJ_STATS_EN
    assign rej_cnt     = rej_q;
`endif

    // Place a new batch directly above the 0..2 leftover bytes.
    always_comb begin
        app_s = '0;
        case (occ_q)
            7'd0:    app_s = {16'h0000, batch_in};
            7'd1:    app_s = {8'h00, batch_in, buf_q[7:0]};
            7'd2:    app_s = {batch_in, buf_q[15:0]};
            default: app_s = {16'h0000, batch_in};
        endcase
    end

    // Next-state computation for the FSM, buffer, phase and coefficient count.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        occ_d   = occ_q;
        phase_d = phase_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                    buf_d   = '0;
                    occ_d   = 7'd0;
                    phase_d = 1'b0;
                    count_d = 9'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (batch_valid) begin
                    buf_d   = app_s;
                    occ_d   = occ_q + BATCH_C;
                    state_d = S_PARSE;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_PARSE: begin
                if (!have_cand_s) begin
                    state_d = S_FILL;
                end else if (advance_s) begin
                    if (cand_ok_s && (count_q == LAST_C)) begin
                        // Last coefficient: leftover bytes and any phase1 candidate are discarded.
                        count_d = count_q + 9'd1;
                        state_d = S_DONE;
                    end else begin
                        if (cand_ok_s) begin
                            count_d = count_q + 9'd1;
                        end else begin
                            count_d = count_q;
                        end
                        if (phase_q) begin
                            buf_d   = buf_q >> 24;
                            occ_d   = occ_q - 7'd3;
                            phase_d = 1'b0;
                            // Refill as soon as fewer than a full triple remains.
                            if (occ_q < 7'd6) begin
                                state_d = S_FILL;
                            end else begin
                                state_d = S_PARSE;
                            end
                        end else begin
                            phase_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = S_PARSE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                buf_d   = '0;
                occ_d   = 7'd0;
                phase_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef REJ_STATS_EN
    // Saturating rejection counter, cleared on start and held after DONE.
    always_comb begin
        rej_d = rej_q;
        if ((state_q == S_IDLE) && start) begin
            rej_d = 16'h0000;
        end else if (have_cand_s && !cand_ok_s && (rej_q != 16'hFFFF)) begin
            rej_d = rej_q + 16'h0001;
        end else begin
            rej_d = rej_q;
        end
    end
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            occ_q   <= 7'd0;
            phase_q <= 1'b0;
            count_q <= 9'd0;
`ifdef REJ_STATS_EN
            rej_q   <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            occ_q   <= occ_d;
            phase_q <= phase_d;
            count_q <= count_d;
`ifdef REJ_STATS_EN
            rej_q   <= rej_d;
`endif
        end
    end

endmodule

// File: tb/tb_aes_ctr_rej_sampler.sv
module tb_aes_ctr_rej_sampler;

    localparam int BB    = 64;
    localparam int NBMAX = 16;
    localparam int SLEN  = BB * NBMAX;
    localparam int QV    = 3329;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [511:0]  batch_in;
    logic          batch_valid;
    logic          batch_ready;
    logic [11:0]   coef_out;
    logic          coef_valid;
    logic          coef_ready;
    logic [7:0]    coef_idx;
    logic          poly_done;
    logic          busy;
`ifdef REJ_STATS_EN
    logic [15:0]   rej_cnt;
`endif

    aes_ctr_rej_sampler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .batch_in    (batch_in),
        .batch_valid (batch_valid),
        .batch_ready (batch_ready),
        .coef_out    (coef_out),
        .coef_valid  (coef_valid),
        .coef_ready  (coef_ready),
        .coef_idx    (coef_idx),
        .poly_done   (poly_done),
        .busy        (busy)
`ifdef REJ_STATS_EN
        ,
        .rej_cnt     (rej_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] stream [SLEN];
    int exp_coef [256];
    int exp_batches;
    int exp_rej;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Byte-stream reference: walk triples, accept candidates below Q until 256 are taken.
    task automatic build_model();
        int acc;
        int t;
        int d;
        acc = 0;
        t = 0;
        exp_rej = 0;
        while (acc < 256 && t < SLEN / 3) begin
            d = (int'(stream[3*t+1]) % 16) * 256 + int'(stream[3*t]);
            if (d < QV) begin exp_coef[acc] = d; acc++; end else exp_rej++;
            if (acc == 256) break;
            d = int'(stream[3*t+2]) * 16 + int'(stream[3*t+1]) / 16;
            if (d < QV) begin exp_coef[acc] = d; acc++; end else exp_rej++;
            if (acc == 256) break;
            t++;
        end
        exp_batches = (3 * (t + 1) + BB - 1) / BB;
    endtask

    // mode 0 zeros, 1 {00,0D,D0}, 2 {01,0D,D0}, 3 FF batch then zeros, 4 random, 5 biased high
    task automatic fill_stream(input int mode);
        for (int i = 0; i < SLEN; i++) begin
            case (mode)
                0: stream[i] = 8'h00;
                1: stream[i] = (i % 3 == 0) ? 8'h00 : ((i % 3 == 1) ? 8'h0D : 8'hD0);
                2: stream[i] = (i % 3 == 0) ? 8'h01 : ((i % 3 == 1) ? 8'h0D : 8'hD0);
                3: stream[i] = (i < BB) ? 8'hFF : 8'h00;
                4: stream[i] = 8'($urandom_range(0, 255));
                default: stream[i] = 8'($urandom_range(150, 255));
            endcase
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(coef_valid), 32'd0);
        chk({tag, "_ready"}, 32'(batch_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(poly_done), 32'd0);
        chk({tag, "_out"}, 32'(coef_out), 32'd0);
        chk({tag, "_idx"}, 32'(coef_idx), 32'd0);
    endtask

    // Runs one polynomial; abort_at > 0 pulses rst once that many coefficients have been taken.
    task automatic run_poly(input int mode, input int abort_at, input bit gap_test);
        int n, bi, hs, done_cnt, gap, stall_left;
        bit finished, prev_stall, gap_arm, stalled_once, start_poked;
        logic [11:0] prev_out;
        logic [7:0]  prev_idx;
        fill_stream(mode);
        build_model();
        n = 0; bi = 0; hs = 0; done_cnt = 0; gap = 0; stall_left = 0;
        finished = 0; prev_stall = 0; gap_arm = 0; stalled_once = 0; start_poked = 0;
        prev_out = '0; prev_idx = '0;
        @(negedge clk);
        start = 1'b1; batch_valid = 1'b0; coef_ready = 1'b1;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (prev_stall) begin
                chk("stall_out", 32'(coef_out), 32'(prev_out));
                chk("stall_idx", 32'(coef_idx), 32'(prev_idx));
            end
            if (gap_arm) begin
                if (batch_ready) begin
                    chk("ready_gap", 32'(gap), 32'd42);
                    gap_arm = 0;
                end else begin
                    gap++;
                    if (coef_valid) chk("ff_valid", 32'(coef_valid), 32'd0);
                end
            end
            if (poly_done) begin
                done_cnt++;
                chk("done_count_n", 32'(n), 32'd256);
                finished = 1;
            end
            if (n == 50 && coef_valid && !stalled_once) begin
                stall_left = 5;
                stalled_once = 1;
            end
            if (stall_left > 0) begin
                coef_ready = 1'b0;
                stall_left--;
            end else begin
                coef_ready = ($urandom_range(0, 3) != 0);
            end
            if (n == 20 && !start_poked) begin
                start = 1'b1;
                start_poked = 1;
            end
            batch_valid = (bi < NBMAX);
            for (int k = 0; k < BB; k++) batch_in[k*8 +: 8] = (bi < NBMAX) ? stream[bi*BB + k] : 8'h00;
            if (batch_ready && batch_valid) begin
                hs++;
                bi++;
                if (gap_test && bi == 1) begin gap_arm = 1; gap = 0; end
            end
            if (coef_valid && coef_ready) begin
                if (n < 256) begin
                    chk("coef_out", 32'(coef_out), 32'(exp_coef[n]));
                    chk("coef_idx", 32'(coef_idx), 32'(n % 256));
                end else begin
                    chk("extra_coef", 32'd1, 32'(n));
                end
                n++;
            end
            prev_stall = coef_valid && !coef_ready;
            prev_out = coef_out;
            prev_idx = coef_idx;
            if (abort_at > 0 && n == abort_at) begin
                #2 rst = 1'b1;
                #1 check_idle_outputs("async_rst");
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                batch_valid = 1'b0;
                return;
            end
        end
        chk("timeout", 32'(finished), 32'd1);
        chk("handshakes", 32'(hs), 32'(exp_batches));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        @(negedge clk);
        batch_valid = 1'b0;
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_done", 32'(poly_done), 32'd0);
`ifdef REJ_STATS_EN
        chk("rej_cnt", 32'(rej_cnt), 32'(exp_rej));
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; batch_valid = 1'b0; coef_ready = 1'b0; batch_in = '0;
        #1 check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle");
        run_poly(0, 0, 0);      // all-zero batches
        run_poly(1, 0, 0);      // 3328 boundary accepted
        run_poly(2, 0, 0);      // 3329 rejected in phase0
        run_poly(3, 0, 1);      // all-0xFF batch: no coefs, refill gap
        run_poly(4, 0, 0);      // random
        run_poly(5, 0, 0);      // random, rejection heavy
        run_poly(4, 100, 0);    // reset mid-PARSE
        check_idle_outputs("after_rst");
        run_poly(4, 0, 0);      // fresh polynomial after reset
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
